// File: rtl/dcache.sv
`default_nettype none
// ============================================================================
// Module   : dcache
// Brief    : Direct-mapped, write-through, no-write-allocate L1 data cache with
//            32B lines and a single outstanding line-fill miss.
// Revision : 1.0
// ============================================================================
module dcache #(
    parameter int SETS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsq_dc_req,
    input  logic [3:0]  lsq_dc_op,
    input  logic [31:0] lsq_dc_addr,
    input  logic [3:0]  lsq_dc_lsqid,
    input  logic [31:0] lsq_dc_wdata,
    input  logic        lsq_dc_flush,
    output logic        dcache_lsq_ready,
    output logic        dcache_lsq_valid,
    output logic        dcache_lsq_error,
    output logic [3:0]  dcache_lsq_lsqid,
    output logic [31:0] dcache_lsq_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int c_IDX_W = $clog2(SETS);
    localparam int c_TAG_W = 27 - c_IDX_W;
    localparam int c_PTR_W = c_IDX_W + 3;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ST_WR     = 2'd1,
        S_MISS_REQ  = 2'd2,
        S_MISS_FILL = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [31:0]        r_data [SETS*8];
    logic [c_TAG_W-1:0] r_tag  [SETS];
    logic [SETS-1:0]    r_vld;

    logic [31:0] r_addr;
    logic [2:0]  r_typ;
    logic [3:0]  r_lsqid;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [2:0]  r_cnt;
    logic        r_cancel;
    logic        r_rsp_valid;
    logic        r_rsp_error;
    logic [3:0]  r_rsp_lsqid;
    logic [31:0] r_rsp_rdata;

    // Byte/half lane select with sign or zero extension by load type.
    function automatic logic [31:0] f_extract(input logic [31:0] word,
                                              input logic [2:0]  typ,
                                              input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (typ)
            3'b000:  f_extract = {{24{b[7]}}, b};
            3'b100:  f_extract = {24'd0, b};
            3'b001:  f_extract = {{16{h[15]}}, h};
            3'b101:  f_extract = {16'd0, h};
            default: f_extract = word;
        endcase
    endfunction

    logic               w_ready, w_accept, w_store, w_type_ok, w_misalign, w_err, w_hit;
    logic [2:0]         w_typ;
    logic [c_IDX_W-1:0] w_idx, w_fidx;
    logic [c_TAG_W-1:0] w_tag;
    logic [c_PTR_W-1:0] w_rd_ptr, w_fill_ptr;
    logic [31:0]        w_fill_word, w_st_data;
    logic [3:0]         w_st_strb;

    assign w_ready     = (r_state == S_IDLE);
    assign w_accept    = lsq_dc_req && w_ready;
    assign w_store     = lsq_dc_op[0];
    assign w_typ       = lsq_dc_op[3:1];
    assign w_type_ok   = w_store ? (w_typ inside {3'b000, 3'b001, 3'b010})
                                 : (w_typ inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign w_misalign  = ((w_typ[1:0] == 2'b01) && lsq_dc_addr[0]) ||
                         ((w_typ[1:0] == 2'b10) && (lsq_dc_addr[1:0] != 2'b00));
    assign w_err       = !w_type_ok || w_misalign;
    assign w_idx       = lsq_dc_addr[5 +: c_IDX_W];
    assign w_tag       = lsq_dc_addr[31 -: c_TAG_W];
    assign w_hit       = r_vld[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_rd_ptr    = {w_idx, lsq_dc_addr[4:2]};
    assign w_fidx      = r_addr[5 +: c_IDX_W];
    assign w_fill_ptr  = {w_fidx, r_cnt};
    // The last beat is not yet in the array when the response is formed.
    assign w_fill_word = (r_addr[4:2] == 3'd7) ? mem_rdata : r_data[{w_fidx, r_addr[4:2]}];

    always_comb begin
        w_st_strb = 4'b1111;
        w_st_data = lsq_dc_wdata;
        case (w_typ[1:0])
            2'b00: begin
                w_st_strb = 4'b0001 << lsq_dc_addr[1:0];
                w_st_data = {4{lsq_dc_wdata[7:0]}};
            end
            2'b01: begin
                w_st_strb = lsq_dc_addr[1] ? 4'b1100 : 4'b0011;
                w_st_data = {2{lsq_dc_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = {r_addr[31:5], 3'b000};
        mem_wstrb   = 4'b0000;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_err) begin
                    if (w_store)     w_state_nxt = S_ST_WR;
                    else if (!w_hit) w_state_nxt = S_MISS_REQ;
                end
            end
            S_ST_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_addr[31:2];
                mem_wstrb = r_wstrb;
                if (mem_ready) w_state_nxt = S_IDLE;
            end
            S_MISS_REQ: begin
                mem_req = 1'b1;
                if (mem_ready) w_state_nxt = S_MISS_FILL;
            end
            S_MISS_FILL: begin
                if (mem_rvalid && (r_cnt == 3'd7)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld       <= '0;
            r_addr      <= '0;
            r_typ       <= '0;
            r_lsqid     <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_cnt       <= '0;
            r_cancel    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_lsqid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr   <= lsq_dc_addr;
                        r_typ    <= w_typ;
                        r_lsqid  <= lsq_dc_lsqid;
                        r_wdata  <= w_st_data;
                        r_wstrb  <= w_st_strb;
                        r_cancel <= lsq_dc_flush;
                        if (!w_store && (w_err || w_hit)) begin
                            r_rsp_valid <= !lsq_dc_flush;
                            r_rsp_error <= w_err;
                            r_rsp_lsqid <= lsq_dc_lsqid;
                            r_rsp_rdata <= w_err ? 32'd0
                                         : f_extract(r_data[w_rd_ptr], w_typ, lsq_dc_addr[1:0]);
                        end
                    end
                end
                S_MISS_REQ: begin
                    if (lsq_dc_flush) r_cancel <= 1'b1;
                    if (mem_ready)    r_cnt    <= 3'd0;
                end
                S_MISS_FILL: begin
                    if (lsq_dc_flush) r_cancel <= 1'b1;
                    if (mem_rvalid) begin
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            r_vld[w_fidx] <= 1'b1;
                            r_rsp_valid   <= !(r_cancel || lsq_dc_flush);
                            r_rsp_lsqid   <= r_lsqid;
                            r_rsp_rdata   <= f_extract(w_fill_word, r_typ, r_addr[1:0]);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage carries no reset; the valid bits alone gate its use.
    always_ff @(posedge clk) begin
        if ((r_state == S_MISS_FILL) && mem_rvalid) begin
            r_data[w_fill_ptr] <= mem_rdata;
            if (r_cnt == 3'd7) r_tag[w_fidx] <= r_addr[31 -: c_TAG_W];
        end else if (w_accept && w_store && !w_err && w_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_st_strb[b]) r_data[w_rd_ptr][b*8 +: 8] <= w_st_data[b*8 +: 8];
            end
        end
    end

    assign dcache_lsq_ready = w_ready;
    assign dcache_lsq_valid = r_rsp_valid;
    assign dcache_lsq_error = r_rsp_error;
    assign dcache_lsq_lsqid = r_rsp_lsqid;
    assign dcache_lsq_rdata = r_rsp_rdata;
    assign mem_wdata        = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dcache.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache
// Brief    : Directed vector bench for dcache with a word-wide bus model.
// Revision : 1.0
// ============================================================================
module tb_dcache;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsq_dc_req = 1'b0;
    logic [3:0]  lsq_dc_op = '0;
    logic [31:0] lsq_dc_addr = '0;
    logic [3:0]  lsq_dc_lsqid = '0;
    logic [31:0] lsq_dc_wdata = '0;
    logic        lsq_dc_flush = 1'b0;
    logic        dcache_lsq_ready, dcache_lsq_valid, dcache_lsq_error;
    logic [3:0]  dcache_lsq_lsqid;
    logic [31:0] dcache_lsq_rdata;
    logic        mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b1;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    localparam logic [3:0] c_LB = 4'b0000, c_LH = 4'b0010, c_LW = 4'b0100;
    localparam logic [3:0] c_LBU = 4'b1000, c_LHU = 4'b1010;
    localparam logic [3:0] c_SB = 4'b0001, c_SH = 4'b0011, c_SW = 4'b0101;

    dcache #(.SETS(64)) dut (
        .clk(clk), .rst(rst),
        .lsq_dc_req(lsq_dc_req), .lsq_dc_op(lsq_dc_op), .lsq_dc_addr(lsq_dc_addr),
        .lsq_dc_lsqid(lsq_dc_lsqid), .lsq_dc_wdata(lsq_dc_wdata), .lsq_dc_flush(lsq_dc_flush),
        .dcache_lsq_ready(dcache_lsq_ready), .dcache_lsq_valid(dcache_lsq_valid),
        .dcache_lsq_error(dcache_lsq_error), .dcache_lsq_lsqid(dcache_lsq_lsqid),
        .dcache_lsq_rdata(dcache_lsq_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rd    = 0;
    int n_wr    = 0;
    int resp_cnt = 0;
    int fill_left = 0;
    logic [29:0] fill_base = '0;
    logic [31:0] mem [0:1023];

    // Bus model: a read request seen now starts 8 beats from the next negedge.
    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        if (fill_left > 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem[int'(fill_base[9:0]) + 8 - fill_left];
            fill_left--;
        end else if (mem_req && !mem_we) begin
            fill_left = 8;
            fill_base = mem_addr;
            n_rd++;
        end
        if (mem_req && mem_we) begin
            n_wr++;
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_addr[9:0]][b*8 +: 8] = mem_wdata[b*8 +: 8];
        end
    end

    always @(posedge clk) if (dcache_lsq_valid) resp_cnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [3:0] id,
                         input logic [31:0] wd, input logic fl);
        int w;
        w = 0;
        @(negedge clk);
        while (!dcache_lsq_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) chk("issue_ready_timeout", {31'd0, dcache_lsq_ready}, 32'd1);
        lsq_dc_req = 1'b1; lsq_dc_op = op; lsq_dc_addr = addr;
        lsq_dc_lsqid = id; lsq_dc_wdata = wd; lsq_dc_flush = fl;
        @(posedge clk);
        #1;
        lsq_dc_req = 1'b0; lsq_dc_flush = 1'b0;
    endtask

    task automatic hit_load(input logic [3:0] op, input logic [31:0] addr, input logic [3:0] id,
                            input logic fl, input logic ev, input logic ee,
                            input logic [31:0] ed, input string nm);
        issue(op, addr, id, 32'd0, fl);
        @(negedge clk);
        chk({nm, "_valid"}, {31'd0, dcache_lsq_valid}, {31'd0, ev});
        if (ev) begin
            chk({nm, "_error"}, {31'd0, dcache_lsq_error}, {31'd0, ee});
            chk({nm, "_lsqid"}, {28'd0, dcache_lsq_lsqid}, {28'd0, id});
            chk({nm, "_rdata"}, dcache_lsq_rdata, ed);
        end
    endtask

    task automatic miss_load(input logic [3:0] op, input logic [31:0] addr, input logic [3:0] id,
                             input logic [31:0] ed, input string nm);
        int  n0;
        bit  got;
        issue(op, addr, id, 32'd0, 1'b0);
        n0  = n_rd;
        got = 1'b0;
        @(negedge clk);
        chk({nm, "_memreq"}, {31'd0, mem_req}, 32'd1);
        chk({nm, "_memaddr"}, {2'd0, mem_addr}, {5'd0, addr[31:5]} << 3);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (dcache_lsq_valid) got = 1'b1;
        end
        chk({nm, "_got_valid"}, {31'd0, got}, 32'd1);
        if (got) begin
            chk({nm, "_lsqid"}, {28'd0, dcache_lsq_lsqid}, {28'd0, id});
            chk({nm, "_rdata"}, dcache_lsq_rdata, ed);
            chk({nm, "_error"}, {31'd0, dcache_lsq_error}, 32'd0);
            @(negedge clk);
            chk({nm, "_pulse"}, {31'd0, dcache_lsq_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        chk({nm, "_nreads"}, n_rd, n0 + 1);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [3:0]  id;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0, rd0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
        for (int k = 0; k < 8; k++) mem[32'h40 + k] = 32'h11 * k;
        mem[32'h80] = 32'h80FF7F01;
        mem[32'h81] = 32'h55667788;

        vecs[0]  = '{c_LW,  32'h104, 4'd1,  1'b0, 32'h00000011};
        vecs[1]  = '{c_LW,  32'h11C, 4'd2,  1'b0, 32'h00000077};
        vecs[2]  = '{c_LB,  32'h203, 4'd4,  1'b0, 32'hFFFFFF80};
        vecs[3]  = '{c_LBU, 32'h203, 4'd5,  1'b0, 32'h00000080};
        vecs[4]  = '{c_LH,  32'h202, 4'd6,  1'b0, 32'hFFFF80FF};
        vecs[5]  = '{c_LHU, 32'h200, 4'd7,  1'b0, 32'h00007F01};
        vecs[6]  = '{c_LB,  32'h201, 4'd8,  1'b0, 32'h0000007F};
        vecs[7]  = '{c_LBU, 32'h202, 4'd9,  1'b0, 32'h000000FF};
        vecs[8]  = '{c_LH,  32'h200, 4'd10, 1'b0, 32'h00007F01};
        vecs[9]  = '{c_LB,  32'h204, 4'd11, 1'b0, 32'hFFFFFF88};
        vecs[10] = '{c_LH,  32'h101, 4'd12, 1'b1, 32'h0};
        vecs[11] = '{4'b0110, 32'h100, 4'd13, 1'b1, 32'h0};
        vecs[12] = '{c_LW,  32'h102, 4'd14, 1'b1, 32'h0};
        vecs[13] = '{4'b1100, 32'h100, 4'd15, 1'b1, 32'h0};
        vecs[14] = '{c_LHU, 32'h203, 4'd0,  1'b1, 32'h0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, dcache_lsq_ready}, 32'd1);
        chk("rst_valid", {31'd0, dcache_lsq_valid}, 32'd0);
        chk("rst_error", {31'd0, dcache_lsq_error}, 32'd0);
        chk("rst_lsqid", {28'd0, dcache_lsq_lsqid}, 32'd0);
        chk("rst_rdata", dcache_lsq_rdata, 32'd0);
        chk("rst_memreq", {31'd0, mem_req}, 32'd0);

        miss_load(c_LW, 32'h100, 4'd3, 32'h0, "cold_miss");
        miss_load(c_LW, 32'h200, 4'd9, 32'h80FF7F01, "miss_200");

        @(posedge clk); #1;
        rd0 = n_rd; w0 = n_wr;
        for (int i = 0; i < 15; i++)
            hit_load(vecs[i].op, vecs[i].addr, vecs[i].id, 1'b0, 1'b1, vecs[i].err,
                     vecs[i].rdata, $sformatf("vec%0d", i));
        @(posedge clk); #1;
        chk("table_no_reads", n_rd, rd0);
        chk("table_no_writes", n_wr, w0);

        issue(c_SB, 32'h201, 4'd0, 32'h000000AA, 1'b0);
        @(negedge clk);
        chk("sb_memreq", {31'd0, mem_req}, 32'd1);
        chk("sb_we", {31'd0, mem_we}, 32'd1);
        chk("sb_addr", {2'd0, mem_addr}, 32'h80);
        chk("sb_wstrb", {28'd0, mem_wstrb}, 32'b0010);
        chk("sb_wdata", mem_wdata, 32'hAAAAAAAA);
        chk("sb_ready", {31'd0, dcache_lsq_ready}, 32'd0);
        hit_load(c_LW, 32'h200, 4'd2, 1'b0, 1'b1, 1'b0, 32'h80FFAA01, "after_sb");

        issue(c_SH, 32'h206, 4'd0, 32'h00001234, 1'b0);
        @(negedge clk);
        chk("sh_addr", {2'd0, mem_addr}, 32'h81);
        chk("sh_wstrb", {28'd0, mem_wstrb}, 32'b1100);
        chk("sh_wdata", mem_wdata, 32'h12341234);
        hit_load(c_LW, 32'h204, 4'd3, 1'b0, 1'b1, 1'b0, 32'h12347788, "after_sh");

        issue(c_SW, 32'h300, 4'd0, 32'hDEADBEEF, 1'b0);
        w0 = n_wr;
        @(negedge clk);
        chk("swmiss_we", {31'd0, mem_we}, 32'd1);
        chk("swmiss_addr", {2'd0, mem_addr}, 32'hC0);
        chk("swmiss_wstrb", {28'd0, mem_wstrb}, 32'hF);
        @(posedge clk); #1;
        chk("swmiss_nwrites", n_wr, w0 + 1);
        miss_load(c_LW, 32'h300, 4'd6, 32'hDEADBEEF, "no_allocate");

        issue(c_SW, 32'h102, 4'd0, 32'h12345678, 1'b0);
        w0 = n_wr; r0 = resp_cnt;
        @(negedge clk);
        chk("badst_memreq", {31'd0, mem_req}, 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        chk("badst_nwrites", n_wr, w0);
        chk("badst_noresp", resp_cnt, r0);

        issue(c_LW, 32'h400, 4'd5, 32'd0, 1'b0);
        r0 = resp_cnt;
        repeat (4) @(negedge clk);
        chk("flushfill_busy", {31'd0, dcache_lsq_ready}, 32'd0);
        lsq_dc_flush = 1'b1;
        @(posedge clk); #1;
        lsq_dc_flush = 1'b0;
        repeat (15) @(negedge clk);
        @(posedge clk); #1;
        chk("flushfill_noresp", resp_cnt, r0);
        rd0 = n_rd;
        hit_load(c_LW, 32'h404, 4'd6, 1'b0, 1'b1, 1'b0, 32'h10000101, "flushfill_hit");
        @(posedge clk); #1;
        chk("flushfill_nomiss", n_rd, rd0);

        hit_load(c_LW, 32'h104, 4'd7, 1'b1, 1'b0, 1'b0, 32'h0, "flush_hit");

        issue(c_LW, 32'h500, 4'd8, 32'd0, 1'b1);
        r0 = resp_cnt;
        repeat (15) @(negedge clk);
        @(posedge clk); #1;
        chk("flushmiss_noresp", resp_cnt, r0);
        hit_load(c_LW, 32'h500, 4'd9, 1'b0, 1'b1, 1'b0, 32'h10000140, "flushmiss_hit");

        issue(c_LW, 32'h600, 4'd1, 32'd0, 1'b0);
        r0 = resp_cnt;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_ready", {31'd0, dcache_lsq_ready}, 32'd1);
        chk("midrst_memreq", {31'd0, mem_req}, 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        @(posedge clk); #1;
        chk("midrst_noresp", resp_cnt, r0);
        miss_load(c_LW, 32'h104, 4'd2, 32'h00000011, "midrst_refill");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
